// File: rtl/sca_stim_engine.sv
// Side-channel stimulus engine: serially configured static/toggle pattern driver
// that runs N toggle cycles, settles, then captures the DUT response for shift-out.
module sca_stim_engine #(
    parameter int unsigned NUM_INS    = 8,
    parameter int unsigned NUM_OUTS   = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                sca_clk,
    input  logic                sca_reset,
    input  logic                sda_in,
    input  logic                sda_load,
    input  logic                start,
    output logic [NUM_INS-1:0]  dut_inputs,
    input  logic [NUM_OUTS-1:0] dut_outputs,
    output logic                busy,
    output logic                done,
    output logic                cap_valid,
    input  logic                shift_out_enable,
    output logic                shift_out_data
);

    localparam int unsigned CW = 2 * NUM_INS + CNT_W;
    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cfg_q, cfg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic                phase_q, phase_d;
    logic [NUM_INS-1:0]  mask_q, mask_d;
    logic [NUM_INS-1:0]  din_q, din_d;
    logic [NUM_OUTS-1:0] cap_q, cap_d;
    logic                cap_valid_q, cap_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [NUM_INS-1:0]  cfg_static;
    logic [NUM_INS-1:0]  cfg_mask;
    logic [CNT_W-1:0]    cfg_n;

    assign cfg_static = cfg_q[NUM_INS-1:0];
    assign cfg_mask   = cfg_q[2*NUM_INS-1:NUM_INS];
    assign cfg_n      = cfg_q[CW-1:2*NUM_INS];

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;
        phase_d     = phase_q;
        mask_d      = mask_q;
        din_d       = din_q;
        cap_d       = cap_q;
        cap_valid_d = cap_valid_q;

        case (state_q)
            IDLE: begin
                if (sda_load) begin
                    cfg_d = {cfg_q[CW-2:0], sda_in};
                end
                if (shift_out_enable) begin
                    cap_d       = cap_q << 1;
                    cap_valid_d = 1'b0;
                end
                // Start samples the configuration as it stood before this cycle's shift
                if (start) begin
                    mask_d  = cfg_mask;
                    cnt_d   = cfg_n;
                    phase_d = 1'b0;
                    din_d   = cfg_static & ~cfg_mask;
                    if (cfg_n != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d  = SETTLE;
                        settle_d = SW'(SETTLE_CYC - 1);
                    end
                end
            end
            RUN: begin
                phase_d = ~phase_q;
                din_d   = (din_q & ~mask_q) | (mask_q & {NUM_INS{~phase_q}});
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d  = SETTLE;
                    settle_d = SW'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            CAPTURE: begin
                cap_d       = dut_outputs;
                cap_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == CAPTURE);
    end

    // State register; synchronous reset overrides everything
    always_ff @(posedge sca_clk) begin
        if (sca_reset) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            cnt_q       <= '0;
            settle_q    <= '0;
            phase_q     <= 1'b0;
            mask_q      <= '0;
            din_q       <= '0;
            cap_q       <= '0;
            cap_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            phase_q     <= phase_d;
            mask_q      <= mask_d;
            din_q       <= din_d;
            cap_q       <= cap_d;
            cap_valid_q <= cap_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dut_inputs     = din_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign cap_valid      = cap_valid_q;
    assign shift_out_data = cap_q[NUM_OUTS-1];

endmodule

// File: tb/tb_sca_stim_engine.sv
// Scoreboard bench for sca_stim_engine: per-cycle busy/done/dut_inputs expectations
// are queued at start and popped on each falling edge.
module tb_sca_stim_engine;

    localparam int unsigned NI = 4;
    localparam int unsigned NO = 4;
    localparam int unsigned CW_T = 8;
    localparam int unsigned SC = 4;
    localparam int unsigned CFGW = 2 * NI + CW_T;

    typedef struct {
        logic          busy;
        logic          done;
        logic [NI-1:0] din;
    } exp_t;

    logic          sca_clk = 1'b0;
    logic          sca_reset;
    logic          sda_in;
    logic          sda_load;
    logic          start;
    logic [NI-1:0] dut_inputs;
    logic [NO-1:0] dut_outputs;
    logic          busy;
    logic          done;
    logic          cap_valid;
    logic          shift_out_enable;
    logic          shift_out_data;

    int            checks = 0;
    int            failures = 0;
    exp_t          exp_q[$];
    logic [CFGW-1:0] cfg_m;
    logic [NO-1:0]   cap_m;

    sca_stim_engine #(
        .NUM_INS(NI), .NUM_OUTS(NO), .CNT_W(CW_T), .SETTLE_CYC(SC)
    ) dut (
        .sca_clk(sca_clk), .sca_reset(sca_reset), .sda_in(sda_in), .sda_load(sda_load),
        .start(start), .dut_inputs(dut_inputs), .dut_outputs(dut_outputs), .busy(busy),
        .done(done), .cap_valid(cap_valid), .shift_out_enable(shift_out_enable),
        .shift_out_data(shift_out_data)
    );

    always #5 sca_clk = ~sca_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer
    always @(negedge sca_clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("sb_busy", 32'(busy), 32'(e.busy));
            check_eq("sb_done", 32'(done), 32'(e.done));
            check_eq("sb_din", 32'(dut_inputs), 32'(e.din));
        end
    end

    task automatic load_cfg(input logic [NI-1:0] st, input logic [NI-1:0] mk,
                            input logic [CW_T-1:0] n);
        logic [CFGW-1:0] v;
        v = {n, mk, st};
        for (int i = CFGW - 1; i >= 0; i--) begin
            sda_in   = v[i];
            sda_load = 1'b1;
            @(posedge sca_clk); #1;
        end
        sda_load = 1'b0;
        sda_in   = 1'b0;
        cfg_m    = v;
    endtask

    task automatic run_seq(input logic [NO-1:0] dout, input bit with_shift, input bit poke);
        logic [NI-1:0]   st, mk, base;
        logic [CW_T-1:0] n;
        int              total, cyc, ph;
        exp_t            e;
        st   = cfg_m[NI-1:0];
        mk   = cfg_m[2*NI-1:NI];
        n    = cfg_m[CFGW-1:2*NI];
        base = st & ~mk;
        dut_outputs      = dout;
        start            = 1'b1;
        shift_out_enable = with_shift;
        if (with_shift) begin
            @(negedge sca_clk);
            check_eq("shift_pre", 32'(shift_out_data), 32'(cap_m[NO-1]));
        end
        @(posedge sca_clk); #1;
        start            = 1'b0;
        shift_out_enable = 1'b0;
        if (with_shift) begin
            cap_m = cap_m << 1;
            check_eq("shift_post", 32'(shift_out_data), 32'(cap_m[NO-1]));
            check_eq("shift_cv_clr", 32'(cap_valid), 32'(0));
        end
        total = int'(n) + int'(SC);
        for (int j = 0; j <= total + 2; j++) begin
            ph     = ((j < int'(n)) ? j : int'(n)) % 2;
            e.busy = (j <= total);
            e.done = (j == total + 1);
            e.din  = base | ((ph == 1) ? mk : '0);
            exp_q.push_back(e);
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            @(posedge sca_clk); #1;
            cyc++;
            if (poke && cyc == 2) begin
                start    = 1'b1;
                sda_load = 1'b1;
                sda_in   = 1'b1;
            end
            if (poke && cyc == 3) begin
                start    = 1'b0;
                sda_load = 1'b0;
                sda_in   = 1'b0;
            end
        end
        if (exp_q.size() > 0) begin
            check_eq("sb_timeout", 32'(exp_q.size()), 32'(0));
            exp_q.delete();
        end
        cap_m = dout;
        check_eq("cap_valid_set", 32'(cap_valid), 32'(1));
        check_eq("cap_msb", 32'(shift_out_data), 32'(dout[NO-1]));
        check_eq("final_din", 32'(dut_inputs), 32'(base | ((n[0] == 1'b1) ? mk : '0)));
    endtask

    initial begin
        int done_cnt;
        sca_reset        = 1'b1;
        sda_in           = 1'b0;
        sda_load         = 1'b0;
        start            = 1'b0;
        shift_out_enable = 1'b0;
        dut_outputs      = '0;
        cfg_m            = '0;
        cap_m            = '0;
        repeat (2) @(posedge sca_clk);
        #1 sca_reset = 1'b0;

        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        check_eq("rst_cap_valid", 32'(cap_valid), 32'(0));
        check_eq("rst_din", 32'(dut_inputs), 32'(0));
        check_eq("rst_sod", 32'(shift_out_data), 32'(0));

        // Toggle run with N=3
        load_cfg(4'b1010, 4'b0011, 8'd3);
        run_seq(4'h5, 1'b0, 1'b0);
        check_eq("n3_final", 32'(dut_inputs), 32'(4'b1011));

        // N=0 goes straight to settle; then shift the capture out
        load_cfg(4'b0110, 4'b1001, 8'd0);
        run_seq(4'hC, 1'b0, 1'b0);
        shift_out_enable = 1'b1;
        for (int i = 0; i < NO; i++) begin
            @(negedge sca_clk);
            check_eq("shift_bit", 32'(shift_out_data), 32'(cap_m[NO-1]));
            cap_m = cap_m << 1;
            if (i == NO - 1) shift_out_enable = 1'b0;
            @(posedge sca_clk); #1;
        end
        check_eq("shift_cv_clr", 32'(cap_valid), 32'(0));

        // Start and sda_load while busy must be ignored; rerun proves CFG intact
        load_cfg(4'b0101, 4'b1100, 8'd2);
        run_seq(4'h3, 1'b0, 1'b1);
        run_seq(4'h6, 1'b0, 1'b0);

        // Start and shift in the same idle cycle
        load_cfg(4'b0000, 4'b1111, 8'd1);
        run_seq(4'h8, 1'b0, 1'b0);
        run_seq(4'hA, 1'b1, 1'b0);

        // Maximum count runs without wrap
        load_cfg(4'b0001, 4'b0010, 8'hFF);
        run_seq(4'h7, 1'b0, 1'b0);

        // Reset in the second RUN cycle
        load_cfg(4'b1111, 4'b0001, 8'd3);
        start = 1'b1;
        @(posedge sca_clk); #1;
        start = 1'b0;
        @(posedge sca_clk); #1;
        sca_reset = 1'b1;
        @(posedge sca_clk); #1;
        sca_reset = 1'b0;
        cfg_m = '0;
        check_eq("midrst_busy", 32'(busy), 32'(0));
        check_eq("midrst_din", 32'(dut_inputs), 32'(0));
        check_eq("midrst_cap_valid", 32'(cap_valid), 32'(0));
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge sca_clk);
            if (done) done_cnt++;
        end
        check_eq("midrst_no_done", 32'(done_cnt), 32'(0));
        check_eq("midrst_idle", 32'(busy), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
